// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, controller FSM states and
// the grant-source encoding used by the memory controller.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_IGNT,
        MC_DGNT
    } memctl_state_t;

    localparam logic MC_SRC_I = 1'b0;
    localparam logic MC_SRC_D = 1'b1;

endpackage

// File: rtl/memory_control.sv
// Single-CPU memory controller: arbitrates icache/dcache requests onto the
// one RAM port and returns wait/load; coherence outputs are held inert.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 1,
    parameter bit IFAIR = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS*32-1:0]   ccsnoopaddr
);

    if (CPUS != 1) begin : g_cpus_check
        $error("memory_control: only CPUS=1 is supported");
    end

    memctl_state_t state, next_state;
    logic          last_grant, next_last_grant;
    logic          ireq, dreq;

    // Coherence inputs have no meaning with a single CPU.
    logic unused_cc;
    assign unused_cc = ^{ccwrite, cctrans};

    assign ccwait      = '0;
    assign ccinv       = '0;
    assign ccsnoopaddr = '0;

    assign ireq = iREN[0];
    assign dreq = dREN[0] | dWEN[0];

    // NOTE: reset is synchronous, so RST only takes effect at the next rising edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= MC_IDLE;
            last_grant <= MC_SRC_I;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state      = state;
        next_last_grant = last_grant;
        iwait           = '1;
        dwait           = '1;
        iload           = '0;
        dload           = '0;
        ramREN          = 1'b0;
        ramWEN          = 1'b0;
        ramaddr         = '0;
        ramstore        = '0;

        unique case (state)
            MC_IDLE: begin
                if (ireq && dreq) begin
                    next_state = (IFAIR && last_grant == MC_SRC_D) ? MC_IGNT : MC_DGNT;
                end else if (ireq) begin
                    next_state = MC_IGNT;
                end else if (dreq) begin
                    next_state = MC_DGNT;
                end
            end

            MC_IGNT: begin
                if (!ireq) begin
                    next_state = MC_IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[31:0];
                    if (ramstate == ACCESS) begin
                        iwait[0]        = 1'b0;
                        iload[31:0]     = ramload;
                        next_last_grant = MC_SRC_I;
                        next_state      = MC_IDLE;
                    end
                end
            end

            MC_DGNT: begin
                if (!dreq) begin
                    next_state = MC_IDLE;
                end else begin
                    ramWEN   = dWEN[0];
                    ramREN   = dREN[0] & ~dWEN[0];
                    ramaddr  = daddr[31:0];
                    ramstore = dstore[31:0];
                    if (ramstate == ACCESS) begin
                        dwait[0]        = 1'b0;
                        // Writes complete with zero data on the load bus.
                        dload[31:0]     = dWEN[0] ? '0 : ramload;
                        next_last_grant = MC_SRC_D;
                        next_state      = MC_IDLE;
                    end
                end
            end

            default: next_state = MC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_control.sv
// Bench for memory_control: a fair (IFAIR=1) and a priority (IFAIR=0) instance
// share stimulus and are checked against a transaction-level port-ownership model.
module tb_memory_control;
    import cpu_types_pkg::*;

    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [0:0]  iREN, dREN, dWEN, ccwrite, cctrans;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;

    logic [0:0]  iwait_o   [2];
    logic [0:0]  dwait_o   [2];
    logic [31:0] iload_o   [2];
    logic [31:0] dload_o   [2];
    logic        ramren_o  [2];
    logic        ramwen_o  [2];
    logic [31:0] ramaddr_o [2];
    logic [31:0] ramstore_o[2];
    logic [0:0]  ccwait_o  [2];
    logic [0:0]  ccinv_o   [2];
    logic [31:0] ccsnoop_o [2];

    // Model: who currently owns the RAM port, and whether D was served last.
    int owner [2];
    bit last_d[2];
    bit fair  [2] = '{1'b1, 1'b0};

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    memory_control #(.CPUS(1), .IFAIR(1'b1)) dut_fair (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramload(ramload), .ramstate(ramstate),
        .ccwrite(ccwrite), .cctrans(cctrans), .iwait(iwait_o[0]), .dwait(dwait_o[0]),
        .iload(iload_o[0]), .dload(dload_o[0]), .ramREN(ramren_o[0]), .ramWEN(ramwen_o[0]),
        .ramaddr(ramaddr_o[0]), .ramstore(ramstore_o[0]), .ccwait(ccwait_o[0]),
        .ccinv(ccinv_o[0]), .ccsnoopaddr(ccsnoop_o[0])
    );

    memory_control #(.CPUS(1), .IFAIR(1'b0)) dut_prio (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramload(ramload), .ramstate(ramstate),
        .ccwrite(ccwrite), .cctrans(cctrans), .iwait(iwait_o[1]), .dwait(dwait_o[1]),
        .iload(iload_o[1]), .dload(dload_o[1]), .ramREN(ramren_o[1]), .ramWEN(ramwen_o[1]),
        .ramaddr(ramaddr_o[1]), .ramstore(ramstore_o[1]), .ccwait(ccwait_o[1]),
        .ccinv(ccinv_o[1]), .ccsnoopaddr(ccsnoop_o[1])
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_str(input string tag, input string observed, input string expected);
        vectors++;
        assert (observed == expected) else begin
            miscompares++;
            $error("FAIL %s observed=%s expected=%s", tag, observed, expected);
        end
    endtask

    // Compare one instance with the model for the current cycle, then advance the model.
    task automatic model_check(input int m);
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        bit          ireq, dreq, done, dropped;
        string       p;
        p       = (m == 0) ? "fair" : "prio";
        ireq    = iREN[0];
        dreq    = dREN[0] | dWEN[0];
        e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_iload = '0;   e_dload = '0;   e_addr = '0;  e_store = '0;
        done    = 1'b0; dropped = 1'b0;

        if (owner[m] == OWN_I) begin
            if (!ireq) dropped = 1'b1;
            else begin
                e_ren  = 1'b1;
                e_addr = iaddr;
                if (ramstate == ACCESS) begin
                    e_iwait = 1'b0; e_iload = ramload; done = 1'b1;
                end
            end
        end else if (owner[m] == OWN_D) begin
            if (!dreq) dropped = 1'b1;
            else begin
                e_wen   = dWEN[0];
                e_ren   = dREN[0] && !dWEN[0];
                e_addr  = daddr;
                e_store = dstore;
                if (ramstate == ACCESS) begin
                    e_dwait = 1'b0;
                    e_dload = dWEN[0] ? 32'h0 : ramload;
                    done    = 1'b1;
                end
            end
        end

        check({p, ".iwait"},    iwait_o[m],    e_iwait);
        check({p, ".dwait"},    dwait_o[m],    e_dwait);
        check({p, ".iload"},    iload_o[m],    e_iload);
        check({p, ".dload"},    dload_o[m],    e_dload);
        check({p, ".ramREN"},   ramren_o[m],   e_ren);
        check({p, ".ramWEN"},   ramwen_o[m],   e_wen);
        check({p, ".ramaddr"},  ramaddr_o[m],  e_addr);
        check({p, ".ramstore"}, ramstore_o[m], e_store);
        check({p, ".cc"}, {ccwait_o[m], ccinv_o[m], ccsnoop_o[m]}, 64'h0);

        if (RST) begin
            owner[m]  = OWN_NONE;
            last_d[m] = 1'b0;
        end else if (owner[m] != OWN_NONE) begin
            if (done) last_d[m] = (owner[m] == OWN_D);
            if (done || dropped) owner[m] = OWN_NONE;
        end else if (ireq && dreq) begin
            owner[m] = (fair[m] && last_d[m]) ? OWN_I : OWN_D;
        end else if (ireq) begin
            owner[m] = OWN_I;
        end else if (dreq) begin
            owner[m] = OWN_D;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        for (int m = 0; m < 2; m++) model_check(m);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(); nxt();
        step(); nxt();
        RST = 1'b0;
    endtask

    initial begin
        int    wen_cycles, dwait_low, dwait_low_at;
        string log_fair, log_prio;

        idle_inputs();
        ccwrite = 1'b0;
        cctrans = 1'b0;
        RST     = 1'b1;
        @(posedge CLK);
        #1;
        for (int m = 0; m < 2; m++) begin
            owner[m]  = OWN_NONE;
            last_d[m] = 1'b0;
        end

        // Reset held two cycles, then inert outputs.
        do_reset();
        step();
        check("reset.iwait", iwait_o[0], 1'b1);
        check("reset.dwait", dwait_o[0], 1'b1);
        check("reset.strobes", {ramren_o[0], ramwen_o[0]}, 2'b00);
        check("reset.ramaddr", ramaddr_o[0], 32'h0);
        nxt();

        // Lone instruction fetch with RAM answering on the first grant cycle.
        iREN = 1'b1; iaddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = ACCESS;
        step();
        check("ifetch.c1.ramREN", ramren_o[0], 1'b0);
        check("ifetch.c1.iwait", iwait_o[0], 1'b1);
        nxt();
        step();
        check("ifetch.c2.ramREN", ramren_o[0], 1'b1);
        check("ifetch.c2.ramaddr", ramaddr_o[0], 32'h100);
        check("ifetch.c2.iwait", iwait_o[0], 1'b0);
        check("ifetch.c2.iload", iload_o[0], 32'hDEADBEEF);
        nxt();
        iREN = 1'b0;
        step();
        check("ifetch.c3.iwait", iwait_o[0], 1'b1);
        nxt();

        // Continuous contention from a fresh reset (last grant = I).
        do_reset();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000;
        ramload = 32'h0BADCAFE; ramstate = ACCESS;
        log_fair = ""; log_prio = "";
        for (int c = 0; c < 8; c++) begin
            step();
            if (iwait_o[0] == 1'b0) log_fair = {log_fair, "I"};
            if (dwait_o[0] == 1'b0) log_fair = {log_fair, "D"};
            if (iwait_o[1] == 1'b0) log_prio = {log_prio, "I"};
            if (dwait_o[1] == 1'b0) log_prio = {log_prio, "D"};
            nxt();
        end
        check_str("contend.fair.order", log_fair, "DIDI");
        check_str("contend.prio.order", log_prio, "DDDD");
        idle_inputs();
        step(); nxt();

        // Write with three BUSY cycles before ACCESS.
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hCAFEF00D;
        wen_cycles = 0; dwait_low = 0; dwait_low_at = -1;
        for (int c = 0; c < 5; c++) begin
            ramstate = (c == 4) ? ACCESS : BUSY;
            step();
            if (ramwen_o[0] && ramstore_o[0] == 32'hCAFEF00D && ramaddr_o[0] == 32'h200)
                wen_cycles++;
            if (dwait_o[0] == 1'b0) begin
                dwait_low++;
                dwait_low_at = c;
            end
            nxt();
        end
        check("write.wen_cycles", wen_cycles, 4);
        check("write.dwait_low", dwait_low, 1);
        check("write.dwait_low_at", dwait_low_at, 4);
        idle_inputs();
        step(); nxt();

        // Read retried through two ERROR cycles.
        dREN = 1'b1; daddr = 32'h300; ramload = 32'h12345678; ramstate = FREE;
        step(); nxt();
        for (int c = 0; c < 2; c++) begin
            ramstate = ERROR;
            step();
            check("error.ramREN", ramren_o[0], 1'b1);
            check("error.dwait", dwait_o[0], 1'b1);
            nxt();
        end
        ramstate = ACCESS;
        step();
        check("error.done.dwait", dwait_o[0], 1'b0);
        check("error.done.dload", dload_o[0], 32'h12345678);
        nxt();
        idle_inputs();
        step(); nxt();

        // Request dropped mid-grant, then reset mid-grant.
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        step(); nxt();
        step();
        check("abort.granted.ramREN", ramren_o[0], 1'b1);
        nxt();
        dREN = 1'b0;
        step();
        check("abort.drop.ramREN", ramren_o[0], 1'b0);
        nxt();
        dREN = 1'b1;
        step();
        check("abort.idle.ramREN", ramren_o[0], 1'b0);
        nxt();
        step(); nxt();
        RST = 1'b1;
        step(); nxt();
        RST = 1'b0;
        step();
        check("rst_mid.ramREN", ramren_o[0], 1'b0);
        check("rst_mid.dwait", dwait_o[0], 1'b1);
        check("rst_mid.ramaddr", ramaddr_o[0], 32'h0);
        nxt();
        idle_inputs();
        step(); nxt();

        // Randomised traffic with drops, mixed RAM states and occasional reset.
        for (int c = 0; c < 800; c++) begin
            RST      = ($urandom_range(0, 79) == 0);
            iREN     = 1'($urandom_range(0, 3) != 0);
            dREN     = 1'($urandom_range(0, 2) != 0);
            dWEN     = 1'($urandom_range(0, 3) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = ramstate_t'(2'($urandom_range(0, 3)));
            step();
            nxt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
